// File: rtl/tone_div_poly_pkg.sv
// Shared constants and helpers for the polyphonic tone divider.
// Base half-period table, octave limits, key and pitch helpers.
package tone_pkg;

    localparam int KEY_MAX = 12;

    localparam int unsigned BASE_DIV [KEY_MAX] = '{
        631, 596, 562, 531, 501, 473,
        446, 421, 398, 375, 354, 334
    };

    localparam int OCT_MIN = -2;
    localparam int OCT_MAX = 2;

    // Highest pressed key wins; with no key pressed the old index is kept.
    function automatic logic [3:0] prio_hold(
        input logic [KEY_MAX-1:0] keys,
        input logic [3:0]         held
    );
        logic [3:0] idx;
        idx = held;
        for (int k = 0; k < KEY_MAX; k++) begin
            if (keys[k]) begin
                idx = 4'(k);
            end
        end
        return idx;
    endfunction

    function automatic int oct_clamp(input int oct);
        int o;
        o = oct;
        if (o < OCT_MIN) begin
            o = OCT_MIN;
        end
        if (o > OCT_MAX) begin
            o = OCT_MAX;
        end
        return o;
    endfunction

    // Positive octave halves the half period, negative doubles it.
    function automatic logic [31:0] shift_clamp(
        input logic [3:0]  idx,
        input int          oct,
        input logic [31:0] term_max
    );
        logic [31:0] base;
        logic [31:0] res;
        base = (idx < 4'(KEY_MAX)) ? BASE_DIV[idx] : BASE_DIV[0];
        if (oct >= 0) begin
            res = base >> oct;
        end else begin
            res = base << (-oct);
        end
        if (res < 32'd2) begin
            res = 32'd2;
        end
        if (res > term_max) begin
            res = term_max;
        end
        return res;
    endfunction

endpackage

// File: rtl/tone_div_poly_if.sv
// Key/octave inputs and per-voice wave, tick and gate outputs.
// The input-logic side is master, the divider is slave.
interface tone_div_poly_if #(
    parameter int NUM_VOICES = 2,
    parameter int NUM_KEYS   = 12,
    parameter int OCT_W      = 3
);

    logic [NUM_VOICES*NUM_KEYS-1:0] keys;
    logic [NUM_VOICES*OCT_W-1:0]    octave;
    logic [NUM_VOICES-1:0]          wave;
    logic [NUM_VOICES-1:0]          tick;
    logic [NUM_VOICES-1:0]          gate;

    modport master (
        output keys,
        output octave,
        input  wave,
        input  tick,
        input  gate
    );

    modport slave (
        input  keys,
        input  octave,
        output wave,
        output tick,
        output gate
    );

endinterface

// File: rtl/tone_voice.sv
// One tone channel: key/octave decode, pitch lookup and the
// half-period divider with retune only at wave toggles.
module tone_voice
    import tone_pkg::*;
#(
    parameter int NUM_KEYS = 12,
    parameter int CNT_W    = 24,
    parameter int OCT_W    = 3
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_KEYS-1:0]     keys,
    input  logic signed [OCT_W-1:0] octave,
    output logic                    wave,
    output logic                    tick,
    output logic                    gate
);

    localparam logic [31:0] TERM_MAX = 32'((64'd1 << CNT_W) - 64'd1);
    localparam logic [CNT_W-1:0] TERM_RST = CNT_W'(BASE_DIV[0]);

    logic [KEY_MAX-1:0] keys_full;
    logic [3:0]         key_idx;
    logic               gate_s1;
    logic signed [2:0]  oct_s1;

    logic [CNT_W-1:0]   pend_term;
    logic               gate_s2;

    logic               gate_q;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   active_term;
    logic [CNT_W-1:0]   cnt_nxt;
    logic [CNT_W-1:0]   term_nxt;
    logic               wave_nxt;

    assign keys_full = KEY_MAX'(keys);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_idx <= '0;
            gate_s1 <= 1'b0;
            oct_s1  <= '0;
        end else begin
            key_idx <= prio_hold(keys_full, key_idx);
            gate_s1 <= |keys;
            oct_s1  <= 3'(oct_clamp(int'(octave)));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_term <= '0;
            gate_s2   <= 1'b0;
        end else begin
            pend_term <= CNT_W'(shift_clamp(key_idx, int'(oct_s1), TERM_MAX));
            gate_s2   <= gate_s1;
        end
    end

    // The gate-rise cycle already counts as the first cycle of the half
    // period, so the first wave rise lands active_term cycles after gate.
    always_comb begin
        cnt_nxt  = cnt + 1'b1;
        term_nxt = active_term;
        wave_nxt = wave;
        if (!gate_s2) begin
            cnt_nxt  = '0;
            wave_nxt = 1'b0;
        end else if (!gate_q) begin
            cnt_nxt  = CNT_W'(1);
            term_nxt = pend_term;
            wave_nxt = 1'b0;
        end else if (cnt == active_term - 1'b1) begin
            cnt_nxt  = '0;
            term_nxt = pend_term;
            wave_nxt = ~wave;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gate_q      <= 1'b0;
            cnt         <= '0;
            active_term <= TERM_RST;
            wave        <= 1'b0;
            tick        <= 1'b0;
        end else begin
            gate_q      <= gate_s2;
            cnt         <= cnt_nxt;
            active_term <= term_nxt;
            wave        <= wave_nxt;
            tick        <= wave_nxt & ~wave;
        end
    end

    assign gate = gate_s2;

endmodule

// File: rtl/tone_div_poly.sv
// Multi-voice tone divider: slices the buses and builds one
// independent tone_voice per channel.
module tone_div_poly
    import tone_pkg::*;
#(
    parameter int NUM_VOICES = 2,
    parameter int NUM_KEYS   = 12,
    parameter int CNT_W      = 24,
    parameter int OCT_W      = 3
) (
    input logic             clk,
    input logic             rst_n,
    tone_div_poly_if.slave  bus
);

    for (genvar v = 0; v < NUM_VOICES; v++) begin : g_voice
        tone_voice #(
            .NUM_KEYS (NUM_KEYS),
            .CNT_W    (CNT_W),
            .OCT_W    (OCT_W)
        ) u_voice (
            .clk    (clk),
            .rst_n  (rst_n),
            .keys   (bus.keys[v*NUM_KEYS +: NUM_KEYS]),
            .octave (bus.octave[v*OCT_W +: OCT_W]),
            .wave   (bus.wave[v]),
            .tick   (bus.tick[v]),
            .gate   (bus.gate[v])
        );
    end

endmodule

// File: tb/tb_tone_div_poly.sv
// Bench for tone_div_poly: octave table, retune, release,
// mid-period reset and two-voice independence.
module tb_tone_div_poly;

    localparam int NV = 2;
    localparam int NK = 12;
    localparam int OW = 3;

    logic clk;
    logic rst_n;
    int   cyc;
    int   checks;
    int   errors;
    bit   mon_en;
    logic [NV-1:0] prev_wave;
    int   exp_q [NV][$];

    tone_div_poly_if #(.NUM_VOICES(NV), .NUM_KEYS(NK), .OCT_W(OW)) bus ();

    tone_div_poly #(
        .NUM_VOICES (NV),
        .NUM_KEYS   (NK),
        .CNT_W      (24),
        .OCT_W      (OW)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          ch;
        logic [11:0] keys;
        int          oct;
        int          half;
        string       name;
    } vec_t;

    vec_t vecs [9];

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0d want %0d", nm, act, exp);
        end
    endtask

    task automatic set_ch(input int ch, input logic [11:0] k, input int oct);
        bus.keys[ch*NK +: NK]   = k;
        bus.octave[ch*OW +: OW] = OW'(oct);
    endtask

    task automatic quiet();
        bus.keys   = '0;
        bus.octave = '0;
        repeat (6) @(negedge clk);
    endtask

    task automatic wait_lvl(input int ch, input bit sel_gate, input bit lvl,
                            input int budget, input string nm, output int t);
        logic s;
        t = -1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            s = sel_gate ? bus.gate[ch] : bus.wave[ch];
            if (s === lvl) begin
                t = cyc;
                return;
            end
        end
        checks++;
        errors++;
        $display("FAIL %s timeout ch%0d lvl %0d", nm, ch, lvl);
    endtask

    // Pops the expected half period and checks gate latency, first rise,
    // high and low phases; returns the time of the second rise.
    task automatic measure(input int ch, input int t0, input string nm,
                           output int tlast);
        int half, tg, tr, tf, tr2;
        tlast = -1;
        checks++;
        if (exp_q[ch].size() == 0) begin
            errors++;
            $display("FAIL %s scoreboard empty ch%0d", nm, ch);
            return;
        end
        half = exp_q[ch].pop_front();
        wait_lvl(ch, 1'b1, 1'b1, 8, nm, tg);
        chk({nm, " gate_lat"}, tg - t0, 2);
        wait_lvl(ch, 1'b0, 1'b1, half + 8, nm, tr);
        chk({nm, " first_rise"}, tr - tg, half);
        wait_lvl(ch, 1'b0, 1'b0, half + 8, nm, tf);
        chk({nm, " high"}, tf - tr, half);
        wait_lvl(ch, 1'b0, 1'b1, half + 8, nm, tr2);
        chk({nm, " low"}, tr2 - tf, half);
        tlast = tr2;
    endtask

    initial begin
        int t0, t, tl, tl1;

        vecs[0] = '{0, 12'h001,  0,  631, "oct0"};
        vecs[1] = '{0, 12'h001,  1,  315, "oct+1"};
        vecs[2] = '{0, 12'h001, -1, 1262, "oct-1"};
        vecs[3] = '{0, 12'h001,  2,  157, "oct+2"};
        vecs[4] = '{0, 12'h001, -2, 2524, "oct-2"};
        vecs[5] = '{0, 12'h001,  3,  157, "oct+3clamp"};
        vecs[6] = '{0, 12'h001, -4, 2524, "oct-4clamp"};
        vecs[7] = '{0, 12'h088,  0,  421, "keys3and7"};
        vecs[8] = '{1, 12'h800,  1,  167, "ch1key11"};

        cyc       = 0;
        checks    = 0;
        errors    = 0;
        mon_en    = 1'b0;
        prev_wave = '0;
        rst_n     = 1'b0;
        bus.keys   = '0;
        bus.octave = '0;

        fork
            forever begin
                @(negedge clk);
                if (mon_en) begin
                    for (int v = 0; v < NV; v++) begin
                        checks++;
                        if (bus.tick[v] !== (bus.wave[v] & ~prev_wave[v] & bus.gate[v])) begin
                            errors++;
                            $display("FAIL tick ch%0d got %b wave %b prev %b gate %b",
                                     v, bus.tick[v], bus.wave[v], prev_wave[v], bus.gate[v]);
                        end
                    end
                end
                prev_wave = bus.wave;
            end
        join_none

        repeat (3) @(negedge clk);
        chk("in_reset", int'({bus.wave, bus.tick, bus.gate}), 0);
        rst_n = 1'b1;
        repeat (100) @(negedge clk);
        chk("idle_100", int'({bus.wave, bus.tick, bus.gate}), 0);
        mon_en = 1'b1;

        for (int i = 0; i < 9; i++) begin
            quiet();
            set_ch(vecs[i].ch, vecs[i].keys, vecs[i].oct);
            t0 = cyc;
            exp_q[vecs[i].ch].push_back(vecs[i].half);
            measure(vecs[i].ch, t0, vecs[i].name, tl);
        end

        // Retune mid half-period: current phase finishes at the old pitch.
        quiet();
        set_ch(0, 12'h088, 0);
        t0 = cyc;
        exp_q[0].push_back(421);
        measure(0, t0, "retune_pre", tl);
        repeat (100) @(negedge clk);
        set_ch(0, 12'h800, 0);
        wait_lvl(0, 1'b0, 1'b0, 500, "retune", t);
        chk("retune_old_half", t - tl, 421);
        tl = t;
        wait_lvl(0, 1'b0, 1'b1, 500, "retune", t);
        chk("retune_new_low", t - tl, 334);
        tl = t;
        wait_lvl(0, 1'b0, 1'b0, 500, "retune", t);
        chk("retune_new_high", t - tl, 334);

        // Release mid half-period, then re-press.
        quiet();
        set_ch(0, 12'h001, 0);
        t0 = cyc;
        exp_q[0].push_back(631);
        measure(0, t0, "rel_pre", tl);
        repeat (100) @(negedge clk);
        set_ch(0, 12'h000, 0);
        t0 = cyc;
        wait_lvl(0, 1'b1, 1'b0, 8, "release", t);
        chk("release_gate_lat", t - t0, 2);
        chk("release_wave_held", int'(bus.wave[0]), 1);
        @(negedge clk);
        chk("release_wave_low", int'(bus.wave[0]), 0);
        repeat (20) @(negedge clk);
        set_ch(0, 12'h001, 0);
        t0 = cyc;
        exp_q[0].push_back(631);
        measure(0, t0, "repress", tl);

        // Reset mid-period with a retune pending.
        repeat (50) @(negedge clk);
        set_ch(0, 12'h800, 0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_zero", int'({bus.wave, bus.tick, bus.gate}), 0);
        set_ch(0, 12'h001, 0);
        repeat (3) @(negedge clk);
        chk("midrst_hold", int'({bus.wave, bus.tick, bus.gate}), 0);
        rst_n = 1'b1;
        t0 = cyc;
        exp_q[0].push_back(631);
        measure(0, t0, "after_rst", tl);

        // Two voices running together.
        quiet();
        set_ch(0, 12'h001, 0);
        set_ch(1, 12'h800, 1);
        t0 = cyc;
        exp_q[0].push_back(631);
        exp_q[1].push_back(167);
        fork
            measure(0, t0, "dual_ch0", tl);
            measure(1, t0, "dual_ch1", tl1);
        join

        quiet();
        mon_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
